// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush controller for the 5-stage pipeline (IF, ID, EXE, MEM,
// WB). It sequences the multi-cycle data-memory wait with a global freeze. It
// detects RAW hazards between the ID sources and the EXE/MEM destinations and
// inserts a bubble for them. It turns a taken branch resolved in EXE into a
// flush of IF/ID and ID/EXE. It also keeps a saturating stall-cycle counter.
//
// Parameters:
//   MEM_WAIT_CYCLES  freeze cycles per data-memory access (1..255)
//   FWD_EN           1 = forwarding present, only load-use stalls
//                    0 = any RAW match against EXE or MEM stalls
//   CNT_W            width of stall_count
//
// Ports:
//   clk           pipeline clock, rising edge
//   rst           asynchronous active-low reset
//   src1, src2    ID-stage source registers
//   two_src       ID instruction reads src2
//   id_valid      ID holds a real instruction
//   exe_wb_en     EXE instruction writes the register file
//   exe_dest      EXE destination register
//   exe_mem_read  EXE instruction is a load
//   mem_wb_en     MEM instruction writes the register file
//   mem_dest      MEM destination register
//   mem_req       MEM-stage instruction is a load or store
//   branch_taken  EXE resolved a taken branch
//   clr_count     synchronous clear of stall_count
//   freeze        global hold of PC and all pipeline registers
//   hazard_stall  hold PC and IF/ID
//   bubble        load NOP into ID/EXE
//   flush         clear IF/ID and ID/EXE, PC loads branch target
//   mem_busy      controller is in the memory-wait state
//   stall_count   saturating count of stalled cycles
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MEM_WAIT_CYCLES = 6,
    parameter int FWD_EN          = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             two_src,
    input  logic             id_valid,
    input  logic             exe_wb_en,
    input  logic [3:0]       exe_dest,
    input  logic             exe_mem_read,
    input  logic             mem_wb_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_req,
    input  logic             branch_taken,
    input  logic             clr_count,
    output logic             freeze,
    output logic             hazard_stall,
    output logic             bubble,
    output logic             flush,
    output logic             mem_busy,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0]       CNT_LOAD = 8'(MEM_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_next;
    logic [CNT_W-1:0] r_stall_count;

    logic w_freeze;
    logic w_mem_busy;
    logic w_match_exe;
    logic w_match_mem;
    logic w_hazard;
    logic w_hazard_stall;
    logic w_bubble;
    logic w_flush;

    // State register and wait counter. Reset aborts any wait in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Memory-wait sequencing. The request cycle in RUN already freezes, and
    // the counter then covers the remaining MEM_WAIT_CYCLES-1 frozen cycles.
    // The cnt==0 cycle is the release cycle. mem_req is deliberately ignored
    // there, so one access yields exactly MEM_WAIT_CYCLES frozen cycles.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_freeze     = 1'b0;
        w_mem_busy   = 1'b0;
        case (r_state)
            RUN: begin
                if (mem_req) begin
                    w_freeze     = 1'b1;
                    w_state_next = MEM_WAIT;
                    w_cnt_next   = CNT_LOAD;
                end
            end
            MEM_WAIT: begin
                w_mem_busy = 1'b1;
                if (r_cnt != 8'd0) begin
                    w_freeze   = 1'b1;
                    w_cnt_next = r_cnt - 8'd1;
                end else begin
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = RUN;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    // RAW detection. Register numbers are compared as plain 4-bit values.
    always_comb begin
        w_match_exe = exe_wb_en &&
                      ((exe_dest == src1) || (two_src && (exe_dest == src2)));
        w_match_mem = mem_wb_en &&
                      ((mem_dest == src1) || (two_src && (mem_dest == src2)));
        if (FWD_EN != 0) begin
            w_hazard = id_valid && exe_mem_read && w_match_exe;
        end else begin
            w_hazard = id_valid && (w_match_exe || w_match_mem);
        end
    end

    // Priority: freeze, then branch flush, then hazard bubble. A branch seen
    // during a freeze is held in EXE and re-presented at release. A hazarding
    // instruction behind a taken branch is flushed, so it needs no bubble.
    always_comb begin
        w_hazard_stall = 1'b0;
        w_bubble       = 1'b0;
        w_flush        = 1'b0;
        if (!w_freeze) begin
            if (branch_taken) begin
                w_flush = 1'b1;
            end else if (w_hazard) begin
                w_hazard_stall = 1'b1;
                w_bubble       = 1'b1;
            end
        end
    end

    // Saturating stall counter. A clear wins over an increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_count <= '0;
        end else if (clr_count) begin
            r_stall_count <= '0;
        end else if ((w_freeze || w_hazard_stall) && (r_stall_count != CNT_MAX)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    // The combinational outputs are forced low while reset is held.
    always_comb begin
        freeze       = rst & w_freeze;
        hazard_stall = rst & w_hazard_stall;
        bubble       = rst & w_bubble;
        flush        = rst & w_flush;
        mem_busy     = rst & w_mem_busy;
        stall_count  = r_stall_count;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed testbench for pipeline_hazard_ctrl. The dut instance has
// forwarding enabled. The dutNoFwd instance has forwarding disabled. Both
// share all inputs. CNT_W is reduced to 8 so that counter saturation can be
// reached quickly. Inputs change 1 ns after a rising edge. Outputs are
// sampled 2 ns after the edge.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic [3:0]    src1;
    logic [3:0]    src2;
    logic          two_src;
    logic          id_valid;
    logic          exe_wb_en;
    logic [3:0]    exe_dest;
    logic          exe_mem_read;
    logic          mem_wb_en;
    logic [3:0]    mem_dest;
    logic          mem_req;
    logic          branch_taken;
    logic          clr_count;

    logic          freeze, hazard_stall, bubble, flush, mem_busy;
    logic [CW-1:0] stall_count;
    logic          nfFreeze, nfHazardStall, nfBubble, nfFlush, nfMemBusy;
    logic [CW-1:0] nfStallCount;

    int nAsserts = 0;
    int nFail    = 0;

    pipeline_hazard_ctrl #(.MEM_WAIT_CYCLES(6), .FWD_EN(1), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .id_valid(id_valid), .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
        .exe_mem_read(exe_mem_read), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .mem_req(mem_req), .branch_taken(branch_taken), .clr_count(clr_count),
        .freeze(freeze), .hazard_stall(hazard_stall), .bubble(bubble),
        .flush(flush), .mem_busy(mem_busy), .stall_count(stall_count)
    );

    pipeline_hazard_ctrl #(.MEM_WAIT_CYCLES(6), .FWD_EN(0), .CNT_W(CW)) dutNoFwd (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .id_valid(id_valid), .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
        .exe_mem_read(exe_mem_read), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .mem_req(mem_req), .branch_taken(branch_taken), .clr_count(clr_count),
        .freeze(nfFreeze), .hazard_stall(nfHazardStall), .bubble(nfBubble),
        .flush(nfFlush), .mem_busy(nfMemBusy), .stall_count(nfStallCount)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge, which is where inputs change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the ID/EXE/MEM hazard-related inputs in one call.
    task automatic applyStimulus(input logic idv, input logic [3:0] s1,
                                 input logic [3:0] s2, input logic two,
                                 input logic ewb, input logic [3:0] ed,
                                 input logic eload, input logic mwb,
                                 input logic [3:0] md);
        id_valid     = idv;
        src1         = s1;
        src2         = s2;
        two_src      = two;
        exe_wb_en    = ewb;
        exe_dest     = ed;
        exe_mem_read = eload;
        mem_wb_en    = mwb;
        mem_dest     = md;
    endtask

    // One comparison: count it, and report tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pack the five control outputs as {freeze,hazard_stall,bubble,flush,mem_busy}.
    function automatic logic [31:0] ctl();
        return {27'd0, freeze, hazard_stall, bubble, flush, mem_busy};
    endfunction

    function automatic logic [31:0] ctlNf();
        return {27'd0, nfFreeze, nfHazardStall, nfBubble, nfFlush, nfMemBusy};
    endfunction

    logic [6:0] expFreeze;
    logic [6:0] expBusy;
    logic [6:0] expFlush;

    initial begin
        // Hold reset with every stimulus that could raise an output.
        rst          = 1'b0;
        clr_count    = 1'b0;
        mem_req      = 1'b1;
        branch_taken = 1'b1;
        applyStimulus(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 4'd3);
        #2;
        checkOutput("reset_ctl",        ctl(),        32'h0);
        checkOutput("reset_ctl_nofwd",  ctlNf(),      32'h0);
        checkOutput("reset_count",      stall_count,  32'h0);
        mem_req      = 1'b0;
        branch_taken = 1'b0;
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        tick();
        tick();
        rst = 1'b1;

        // Idle with no requests for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            checkOutput($sformatf("idle_ctl_%0d", i), ctl(), 32'h0);
            checkOutput($sformatf("idle_count_%0d", i), stall_count, 32'h0);
        end

        // A single memory access: six frozen cycles, then the release cycle.
        expFreeze = 7'b0111111;
        expBusy   = 7'b1111110;
        mem_req   = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            checkOutput($sformatf("memwait_freeze_%0d", k), freeze, expFreeze[k]);
            checkOutput($sformatf("memwait_busy_%0d", k), mem_busy, expBusy[k]);
            checkOutput($sformatf("memwait_nostall_%0d", k), hazard_stall, 32'h0);
            tick();
            if (k == 5) mem_req = 1'b0;
        end
        #1;
        checkOutput("memwait_after_ctl", ctl(), 32'h0);
        checkOutput("memwait_count", stall_count, 32'd6);
        tick();

        // Load-use hazard on src1: one-cycle stall, then the bubble is in EXE.
        applyStimulus(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0);
        #1;
        checkOutput("loaduse_ctl", ctl(), 32'b01100);
        checkOutput("loaduse_ctl_nofwd", ctlNf(), 32'b01100);
        tick();
        applyStimulus(1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        #1;
        checkOutput("loaduse_cleared", ctl(), 32'h0);
        checkOutput("loaduse_count", stall_count, 32'd7);
        tick();

        // Load-use hazard via src2, only when two_src is set.
        applyStimulus(1'b1, 4'd3, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 4'd0);
        #1;
        checkOutput("src2_hazard", ctl(), 32'b01100);
        two_src = 1'b0;
        #1;
        checkOutput("src2_ignored", ctl(), 32'h0);
        tick();

        // An invalid ID slot never hazards.
        applyStimulus(1'b0, 4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0);
        #1;
        checkOutput("idinvalid_ctl", ctl(), 32'h0);
        checkOutput("idinvalid_ctl_nofwd", ctlNf(), 32'h0);
        tick();

        // A non-load RAW in EXE stalls only without forwarding.
        applyStimulus(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0);
        #1;
        checkOutput("exe_raw_fwd", ctl(), 32'h0);
        checkOutput("exe_raw_nofwd", ctlNf(), 32'b01100);
        tick();

        // A RAW against MEM stalls only without forwarding. r15 is not special.
        applyStimulus(1'b1, 4'd15, 4'd0, 1'b0, 1'b0, 4'd15, 1'b0, 1'b1, 4'd15);
        #1;
        checkOutput("mem_raw_fwd", ctl(), 32'h0);
        checkOutput("mem_raw_nofwd", ctlNf(), 32'b01100);
        tick();

        // A branch beats an active load-use hazard.
        applyStimulus(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0);
        branch_taken = 1'b1;
        #1;
        checkOutput("branch_over_hazard", ctl(), 32'b00010);
        tick();
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);

        // A branch is suppressed during the freeze and flushes at release.
        expFlush = 7'b1000000;
        mem_req  = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            checkOutput($sformatf("branch_freeze_flush_%0d", k), flush, expFlush[k]);
            checkOutput($sformatf("branch_freeze_freeze_%0d", k), freeze, expFreeze[k]);
            tick();
            if (k == 5) mem_req = 1'b0;
        end
        branch_taken = 1'b0;

        // Reset asserted on the third cycle of a memory wait.
        mem_req = 1'b1;
        tick();
        tick();
        #1;
        checkOutput("abort_busy_before", mem_busy, 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("abort_ctl", ctl(), 32'h0);
        checkOutput("abort_count", stall_count, 32'h0);
        mem_req = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checkOutput("abort_release_ctl", ctl(), 32'h0);
        tick();
        #1;
        checkOutput("abort_run_ctl", ctl(), 32'h0);
        checkOutput("abort_run_count", stall_count, 32'h0);

        // A sustained hazard drives the counter to saturation at 8'hFF.
        applyStimulus(1'b1, 4'd7, 4'd0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 254; i++) tick();
        #1;
        checkOutput("sat_count_254", stall_count, 32'd254);
        tick();
        tick();
        tick();
        #1;
        checkOutput("sat_count_hold", stall_count, 32'hFF);
        checkOutput("sat_still_stall", hazard_stall, 32'h1);

        // A clear wins over an increment during a freeze.
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        mem_req   = 1'b1;
        clr_count = 1'b1;
        #1;
        checkOutput("clr_freeze", freeze, 32'h1);
        tick();
        clr_count = 1'b0;
        #1;
        checkOutput("clr_count_zero", stall_count, 32'h0);
        tick();
        #1;
        checkOutput("clr_then_count", stall_count, 32'h1);
        mem_req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        #1;
        checkOutput("clr_final_ctl", ctl(), 32'h0);
        checkOutput("clr_final_count", stall_count, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
